ps2_kbd_matrix: RTL

Keyboard-side responder for the ULA keyboard scan interface. It receives PS/2 set-2 scancodes from a host keyboard and keeps an 8x5 Spectrum key matrix. It answers the ULA's row selects (CPU A[15:8]) with active-low column data on kbcolumns. It replaces the physical membrane and diodes, and sits between the PS/2 pins and the ULA kbrows/kbcolumns ports.

---
 rtl/ps2_kbd_matrix.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_matrix.sv
// PS/2 set-2 keyboard to ZX Spectrum 8x5 key matrix responder for the ULA row scan.
// Optional build macro CURSOR_KEYS_EN adds cursor/backspace keys as CAPS+digit chords.
module ps2_kbd_matrix #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 14000
) (
  input  logic       clk14,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] rows,
  output logic [4:0] kbcolumns,
  output logic [7:0] code,
  output logic       code_strobe,
  output logic       frame_err,
  output logic       key_reset
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef CURSOR_KEYS_EN
  localparam int NCAPS = 7;  // lshift, rshift, left, down, up, right, backspace
`else
  localparam int NCAPS = 2;  // lshift, rshift
`endif

  typedef enum logic [2:0] {
    ST_NORMAL, ST_BREAK, ST_EXT, ST_EXT_BREAK, ST_SKIP
  } dec_state_e;

  logic ps2_clk_s1_q, ps2_clk_s1_d, ps2_clk_s2_q, ps2_clk_s2_d;
  logic ps2_data_s1_q, ps2_data_s1_d, ps2_data_s2_q, ps2_data_s2_d;
  logic filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  dec_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic [39:0] keys_q, keys_d;
  logic [NCAPS-1:0] caps_q, caps_d;
  logic [1:0] sym_q, sym_d;
  logic f12_q, f12_d;
  logic [7:0] code_q, code_d;
  logic strobe_q, strobe_d;
  logic err_q, err_d;

  logic fall, byte_ok, make, ext;
  logic [6:0] map_hit;
  logic [39:0] matrix;
  logic [4:0] col_act;

  // Returns {hit, matrix index} for plain (non-extended) keys; index = row*5 + column.
  function automatic logic [6:0] map_base(input logic [7:0] b);
    case (b)
      8'h1A: map_base = {1'b1, 6'd1};   8'h22: map_base = {1'b1, 6'd2};
      8'h21: map_base = {1'b1, 6'd3};   8'h2A: map_base = {1'b1, 6'd4};
      8'h1C: map_base = {1'b1, 6'd5};   8'h1B: map_base = {1'b1, 6'd6};
      8'h23: map_base = {1'b1, 6'd7};   8'h2B: map_base = {1'b1, 6'd8};
      8'h34: map_base = {1'b1, 6'd9};   8'h15: map_base = {1'b1, 6'd10};
      8'h1D: map_base = {1'b1, 6'd11};  8'h24: map_base = {1'b1, 6'd12};
      8'h2D: map_base = {1'b1, 6'd13};  8'h2C: map_base = {1'b1, 6'd14};
      8'h16: map_base = {1'b1, 6'd15};  8'h1E: map_base = {1'b1, 6'd16};
      8'h26: map_base = {1'b1, 6'd17};  8'h25: map_base = {1'b1, 6'd18};
      8'h2E: map_base = {1'b1, 6'd19};  8'h45: map_base = {1'b1, 6'd20};
      8'h46: map_base = {1'b1, 6'd21};  8'h3E: map_base = {1'b1, 6'd22};
      8'h3D: map_base = {1'b1, 6'd23};  8'h36: map_base = {1'b1, 6'd24};
      8'h4D: map_base = {1'b1, 6'd25};  8'h44: map_base = {1'b1, 6'd26};
      8'h43: map_base = {1'b1, 6'd27};  8'h3C: map_base = {1'b1, 6'd28};
      8'h35: map_base = {1'b1, 6'd29};  8'h5A: map_base = {1'b1, 6'd30};
      8'h4B: map_base = {1'b1, 6'd31};  8'h42: map_base = {1'b1, 6'd32};
      8'h3B: map_base = {1'b1, 6'd33};  8'h33: map_base = {1'b1, 6'd34};
      8'h29: map_base = {1'b1, 6'd35};  8'h3A: map_base = {1'b1, 6'd37};
      8'h31: map_base = {1'b1, 6'd38};  8'h32: map_base = {1'b1, 6'd39};
      default: map_base = 7'd0;
    endcase
  endfunction

  always_comb begin
    ps2_clk_s1_d  = ps2_clk;
    ps2_clk_s2_d  = ps2_clk_s1_q;
    ps2_data_s1_d = ps2_data;
    ps2_data_s2_d = ps2_data_s1_q;
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tmo_d      = tmo_q;
    state_d    = state_q;
    skip_d     = skip_q;
    keys_d     = keys_q;
    caps_d     = caps_q;
    sym_d      = sym_q;
    f12_d      = f12_q;
    code_d     = code_q;
    strobe_d   = 1'b0;
    err_d      = 1'b0;
    fall       = 1'b0;
    byte_ok    = 1'b0;
    make       = 1'b0;
    ext        = 1'b0;
    map_hit    = 7'd0;

    // Glitch filter: the level flips only after FILTER_LEN consecutive differing samples.
    if (ps2_clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_clk_d = ps2_clk_s2_q;
        fall       = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end

    if (fall) begin
      tmo_d = '0;
      case (bit_cnt_q)
        4'd0: begin
          if (ps2_data_s2_q) err_d = 1'b1;
          else               bit_cnt_d = 4'd1;
        end
        4'd9: begin
          parity_d  = ps2_data_s2_q;
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = 4'd0;
          if (ps2_data_s2_q && (^{shift_q, parity_q})) byte_ok = 1'b1;
          else                                       err_d   = 1'b1;
        end
        default: begin
          shift_d   = {ps2_data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      endcase
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = 4'd0;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end

    if (byte_ok) begin
      code_d   = shift_q;
      strobe_d = 1'b1;
      if (state_q == ST_SKIP) begin
        // Pause sequence tail: swallow the remaining bytes without decoding.
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) state_d = ST_NORMAL;
      end else if (shift_q == 8'hE1) begin
        state_d = ST_SKIP;
        skip_d  = 3'd7;
      end else if (shift_q == 8'hF0 && state_q == ST_NORMAL) begin
        state_d = ST_BREAK;
      end else if (shift_q == 8'hF0 && state_q == ST_EXT) begin
        state_d = ST_EXT_BREAK;
      end else if (shift_q == 8'hE0 && state_q == ST_NORMAL) begin
        state_d = ST_EXT;
      end else begin
        make    = (state_q == ST_NORMAL) || (state_q == ST_EXT);
        ext     = (state_q == ST_EXT) || (state_q == ST_EXT_BREAK);
        state_d = ST_NORMAL;
        if (!ext) begin
          map_hit = map_base(shift_q);
          if (map_hit[6]) keys_d[map_hit[5:0]] = make;
          case (shift_q)
            8'h12: caps_d[0] = make;
            8'h59: caps_d[1] = make;
            8'h14: sym_d[0]  = make;
            8'h07: f12_d     = make;
`ifdef CURSOR_KEYS_EN
            8'h66: caps_d[6] = make;
`endif
            default: ;
          endcase
        end else begin
          case (shift_q)
            8'h5A: keys_d[30] = make;
            8'h14: sym_d[1]   = make;
`ifdef CURSOR_KEYS_EN
            8'h6B: caps_d[2] = make;
            8'h72: caps_d[3] = make;
            8'h75: caps_d[4] = make;
            8'h74: caps_d[5] = make;
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // Shared keys are the OR of their sources so one release never cancels another holder.
  always_comb begin
    matrix     = keys_q;
    matrix[0]  = |caps_q;
    matrix[36] = |sym_q;
`ifdef CURSOR_KEYS_EN
    matrix[19] = keys_q[19] | caps_q[2];
    matrix[24] = keys_q[24] | caps_q[3];
    matrix[23] = keys_q[23] | caps_q[4];
    matrix[22] = keys_q[22] | caps_q[5];
    matrix[20] = keys_q[20] | caps_q[6];
`endif
    col_act = 5'b00000;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 5; j++) begin
        if (!rows[i]) col_act[j] = col_act[j] | matrix[i*5 + j];
      end
    end
  end

  always_ff @(posedge clk14 or negedge reset_n) begin
    if (!reset_n) begin
      ps2_clk_s1_q  <= 1'b1;
      ps2_clk_s2_q  <= 1'b1;
      ps2_data_s1_q <= 1'b1;
      ps2_data_s2_q <= 1'b1;
      filt_clk_q    <= 1'b1;
      filt_cnt_q    <= '0;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      parity_q      <= 1'b0;
      tmo_q         <= '0;
      state_q       <= ST_NORMAL;
      skip_q        <= 3'd0;
      keys_q        <= 40'd0;
      caps_q        <= '0;
      sym_q         <= 2'b00;
      f12_q         <= 1'b0;
      code_q        <= 8'h00;
      strobe_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      ps2_clk_s1_q  <= ps2_clk_s1_d;
      ps2_clk_s2_q  <= ps2_clk_s2_d;
      ps2_data_s1_q <= ps2_data_s1_d;
      ps2_data_s2_q <= ps2_data_s2_d;
      filt_clk_q    <= filt_clk_d;
      filt_cnt_q    <= filt_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      tmo_q         <= tmo_d;
      state_q       <= state_d;
      skip_q        <= skip_d;
      keys_q        <= keys_d;
      caps_q        <= caps_d;
      sym_q         <= sym_d;
      f12_q         <= f12_d;
      code_q        <= code_d;
      strobe_q      <= strobe_d;
      err_q         <= err_d;
    end
  end

  assign kbcolumns   = ~col_act;
  assign code        = code_q;
  assign code_strobe = strobe_q;
  assign frame_err   = err_q;
  assign key_reset   = f12_q;

endmodule
